// File: rtl/mult_nxn_fast.sv
// Sequential unsigned WIDTH x WIDTH multiplier built around one CHUNK x CHUNK
// partial multiplier; all-zero upper chunks of either operand are skipped.
module mult_nxn_fast #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SHW = $clog2(2 * WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IW-1:0]      i_q, j_q;
  logic [IW-1:0]      la_q, lb_q;
  logic [2*WIDTH-1:0] product_q;

  logic               accept_s;
  logic               last_s;
  logic [CHUNK-1:0]   a_ch_s, b_ch_s;
  logic [2*CHUNK-1:0] pp_s;
  logic [IW:0]        pos_s;
  logic [SHW-1:0]     shamt_s;
  logic [2*WIDTH-1:0] pp_shift_s;

  // Index of the highest nonzero chunk; 0 for an all-zero operand.
  function automatic logic [IW-1:0] hi_chunk(input logic [WIDTH-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int c = 0; c < NCH; c++) begin
      if (v[c*CHUNK +: CHUNK] != {CHUNK{1'b0}}) begin
        idx = IW'(c);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_s   = (i_q == la_q) && (j_q == lb_q);

  // Partial product of the current chunk pair, aligned to its weight.
  always_comb begin
    a_ch_s     = CHUNK'(a_q >> (SHW'(i_q) * SHW'(CHUNK)));
    b_ch_s     = CHUNK'(b_q >> (SHW'(j_q) * SHW'(CHUNK)));
    pp_s       = {{CHUNK{1'b0}}, a_ch_s} * {{CHUNK{1'b0}}, b_ch_s};
    pos_s      = {1'b0, i_q} + {1'b0, j_q};
    shamt_s    = SHW'(pos_s) * SHW'(CHUNK);
    pp_shift_s = (2*WIDTH)'(pp_s) << shamt_s;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the next state so they register alongside it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_CALC: begin
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      ST_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Operand capture, chunk iteration (i inner, j outer) and accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      la_q      <= '0;
      lb_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      product_q <= '0;
    end else if (accept_s) begin
      a_q       <= a;
      b_q       <= b;
      la_q      <= hi_chunk(a);
      lb_q      <= hi_chunk(b);
      i_q       <= '0;
      j_q       <= '0;
      product_q <= '0;
    end else if (state_q == ST_CALC) begin
      product_q <= product_q + pp_shift_s;
      if (last_s) begin
        i_q <= '0;
        j_q <= '0;
      end else if (i_q == la_q) begin
        i_q <= '0;
        j_q <= j_q + IW'(1);
      end else begin
        i_q <= i_q + IW'(1);
        j_q <= j_q;
      end
    end else begin
      product_q <= product_q;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult_nxn_fast.sv
// Directed-vector bench for mult_nxn_fast at 32/16 and 64/16 configurations.
module tb_mult_nxn_fast;

  logic         clk;
  logic         reset;
  logic         start32, start64;
  logic [31:0]  a32, b32;
  logic [63:0]  a64, b64;
  logic         busy32, done32, busy64, done64;
  logic [63:0]  prod32;
  logic [127:0] prod64;

  int n_vec;
  int n_err;
  logic [127:0] tr [0:31];

  mult_nxn_fast #(.WIDTH(32), .CHUNK(16)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .product(prod32)
  );

  mult_nxn_fast #(.WIDTH(64), .CHUNK(16)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .a(a64), .b(b64),
    .busy(busy64), .done(done64), .product(prod64)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Run one multiplication; poke=1 pulses start and scrambles operands during CALC.
  task automatic run_op(input string tag, input bit w64, input logic [127:0] av,
                        input logic [127:0] bv, input int exp_busy,
                        input logic [127:0] exp_prod, input bit poke);
    int nb;
    int ovl;
    bit got_done;
    logic bsy, dn;
    logic [127:0] pr;
    nb = 0;
    ovl = 0;
    got_done = 1'b0;
    @(negedge clk);
    if (w64) begin
      a64 = av[63:0]; b64 = bv[63:0]; start64 = 1'b1;
    end else begin
      a32 = av[31:0]; b32 = bv[31:0]; start32 = 1'b1;
    end
    @(negedge clk);
    start32 = 1'b0;
    start64 = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      bsy = w64 ? busy64 : busy32;
      dn  = w64 ? done64 : done32;
      pr  = w64 ? prod64 : {64'd0, prod32};
      if (bsy && dn) ovl++;
      if (dn) begin
        got_done = 1'b1;
      end else if (bsy) begin
        if (nb < 32) tr[nb] = pr;
        nb++;
        if (poke) begin
          start32 = 1'b1; start64 = 1'b1;
          a32 = 32'hDEAD_BEEF; b32 = 32'h1357_9BDF;
          a64 = 64'hDEAD_BEEF_0BAD_F00D; b64 = 64'h1357_9BDF_2468_ACE0;
        end
      end
      if (!got_done) @(negedge clk);
    end
    start32 = 1'b0;
    start64 = 1'b0;
    check_val({tag, "_done_seen"}, 128'(got_done), 128'd1);
    check_val({tag, "_busy_cycles"}, 128'(nb), 128'(exp_busy));
    check_val({tag, "_overlap"}, 128'(ovl), 128'd0);
    check_val({tag, "_product"}, w64 ? prod64 : {64'd0, prod32}, exp_prod);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, 128'(w64 ? done64 : done32), 128'd0);
    check_val({tag, "_hold"}, w64 ? prod64 : {64'd0, prod32}, exp_prod);
  endtask

  initial begin
    int nbz, ndz;
    n_vec = 0;
    n_err = 0;
    clk = 1'b0;
    reset = 1'b1;
    start32 = 1'b0; start64 = 1'b0;
    a32 = '0; b32 = '0; a64 = '0; b64 = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy32", 128'(busy32), 128'd0);
    check_val("rst_done32", 128'(done32), 128'd0);
    check_val("rst_prod32", {64'd0, prod32}, 128'd0);
    check_val("rst_busy64", 128'(busy64), 128'd0);
    check_val("rst_done64", 128'(done64), 128'd0);
    check_val("rst_prod64", prod64, 128'd0);
    reset = 1'b0;

    run_op("t1", 1'b0, 128'h1234, 128'h5678, 1, 128'h0626_0060, 1'b0);

    run_op("t2", 1'b0, 128'hFFFF_FFFF, 128'hFFFF_FFFF, 4, 128'hFFFF_FFFE_0000_0001, 1'b1);
    check_val("t2_tr0", tr[0], 128'd0);
    check_val("t2_tr1", tr[1], 128'hFFFE_0001);
    check_val("t2_tr2", tr[2], 128'hFFFE_FFFF_0001);
    check_val("t2_tr3", tr[3], 128'h1_FFFD_0000_0001);

    run_op("t3a", 1'b0, 128'h0001_0000, 128'h3, 2, 128'h3_0000, 1'b0);
    run_op("t3b", 1'b0, 128'h0, 128'hFFFF_FFFF, 2, 128'h0, 1'b0);

    // Hold start high: accept in IDLE, then re-accept every DONE cycle.
    @(negedge clk);
    a32 = 32'd2; b32 = 32'd3; start32 = 1'b1;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      check_val("t4_busy", {126'd0, busy32, done32}, 128'b10);
      a32 = 32'hDEAD_BEEF; b32 = 32'h1357_9BDF;
      @(negedge clk);
      check_val("t4_done", {126'd0, busy32, done32}, 128'b01);
      check_val("t4_prod", {64'd0, prod32}, 128'd6);
      a32 = 32'd2; b32 = 32'd3;
      if (p == 2) start32 = 1'b0;
    end
    @(negedge clk);
    check_val("t4_idle", {126'd0, busy32, done32}, 128'b00);

    // Reset during the second busy cycle aborts with no done pulse.
    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    check_val("t5_busy1", 128'(busy32), 128'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("t5_busy", 128'(busy32), 128'd0);
    check_val("t5_done", 128'(done32), 128'd0);
    check_val("t5_prod", {64'd0, prod32}, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    nbz = 0; ndz = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy32) nbz++;
      if (done32) ndz++;
    end
    check_val("t5_quiet_busy", 128'(nbz), 128'd0);
    check_val("t5_quiet_done", 128'(ndz), 128'd0);
    run_op("t5_again", 1'b0, 128'h1234, 128'h5678, 1, 128'h0626_0060, 1'b0);

    // NA=3, NB=2: trace distinguishes i-inner from j-inner ordering.
    run_op("ord", 1'b1, 128'h0000_0003_0002_0001, 128'h0000_0000_0005_0004, 6,
           128'h000F_0016_000D_0004, 1'b0);
    check_val("ord_tr1", tr[1], 128'h4);
    check_val("ord_tr2", tr[2], 128'h8_0004);
    check_val("ord_tr3", tr[3], 128'hC_0008_0004);
    check_val("ord_tr4", tr[4], 128'hC_000D_0004);
    check_val("ord_tr5", tr[5], 128'h16_000D_0004);

    run_op("t6a", 1'b1, 128'h8000_0000_0000_0000, 128'h2, 4,
           128'h1_0000_0000_0000_0000, 1'b0);
    run_op("t6b", 1'b1, 128'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFF, 16,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
